seg7_scan: RTL

//  Consumes the 16-bit BCD MM:SS countdown value from the timer stage and drives a
//  4-digit, common-anode, multiplexed 7-segment display. Scans the digits, lights the

---
 rtl/seg7_scan.sv | 103 ++++++++++
 1 files changed

// File: rtl/seg7_scan.sv
// seg7_scan: multiplexed 4-digit common-anode 7-segment driver for a BCD MM:SS value.
// Scans one digit per SCAN_DIV cycles, lights the colon on digit 2, optionally blanks
// a leading zero in the tens-of-minutes digit, and blinks the display while alarm is high.
module seg7_scan #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 25000000,
  parameter int LZB       = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bcd,
  input  logic        en,
  input  logic        alarm,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [SW-1:0] scan_cnt;
  logic [1:0]    idx;
  logic [BW-1:0] blink_cnt;
  logic          phase;

  logic          scan_tick;
  logic [3:0]    nib;
  logic [6:0]    dec;
  logic          blank;
  logic          lit;
  logic [3:0]    an_d;
  logic [6:0]    seg_d;
  logic          dp_d;

  assign scan_tick = (scan_cnt == SCAN_LAST);

  // Digit scan: dwell SCAN_DIV cycles on each digit, then move to the next one.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else if (scan_tick) begin
      scan_cnt <= '0;
      idx      <= idx + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // Blink timer: runs only while alarm is held; idle state is the on phase.
  always_ff @(posedge clk) begin
    if (rst || !alarm) begin
      blink_cnt <= '0;
      phase     <= 1'b1;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // Select the active nibble, decode it and work out whether the digit is lit.
  always_comb begin
    nib = bcd[{idx, 2'b00} +: 4];
    dec = 7'b0111111;
    case (nib)
      4'd0:    dec = 7'b1000000;
      4'd1:    dec = 7'b1111001;
      4'd2:    dec = 7'b0100100;
      4'd3:    dec = 7'b0110000;
      4'd4:    dec = 7'b0011001;
      4'd5:    dec = 7'b0010010;
      4'd6:    dec = 7'b0000010;
      4'd7:    dec = 7'b1111000;
      4'd8:    dec = 7'b0000000;
      4'd9:    dec = 7'b0010000;
      default: dec = 7'b0111111;
    endcase
    blank = (LZB != 0) && (idx == 2'd3) && (nib == 4'd0);
    lit   = en && !(alarm && !phase) && !blank;
    an_d  = lit ? ~(4'b0001 << idx) : 4'hF;
    seg_d = blank ? 7'h7F : dec;
    dp_d  = !(lit && (idx == 2'd2));
  end

  // Output register: one cycle of latency from idx/bcd to the pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      an  <= 4'hF;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else begin
      an  <= an_d;
      seg <= seg_d;
      dp  <= dp_d;
    end
  end

endmodule
